move_sequencer: RTL and testbench
=================================

# move_sequencer

Turn controller for the 4x4 Connect-4 board. Owns the occupancy and ownership registers that drive the LED column mapping, turns a debounced button press plus the one-hot column switches into a placed piece, and hands each placement to the win detector. The block alternates players, rejects illegal moves, and latches the game result. It sits between the button/switch inputs and the detector/display path, sequencing both.

## Interface
Parameters:
- none; board fixed at 4 columns x 4 rows.

Ports:
- clk  in  1  system clock (the divided game clock).
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- btn  in  1  debounced drop button, level; rising edge is detected internally.
- sel_col  in  4  column switches, one-hot; bit i selects column i.
- chk_done  in  1  detector result-valid strobe, one cycle.
- chk_win  in  1  detector verdict, sampled only with chk_done: last move completed four-in-a-row.
- gameboard  out  16  occupancy; bit col*4+row, row 0 = bottom.
- player_cells  out  16  owner per cell (0 = player 0, 1 = player 1); meaningful only where gameboard bit is 1.
- player  out  1  player to move.
- chk_req  out  1  one-cycle pulse; the board now holds the new piece.
- bad_move  out  1  one-cycle pulse; the press was rejected.
- status  out  2  00 playing, 01 player 0 won, 10 player 1 won, 11 draw.
- busy  out  1  high in PLACE and CHECK.

## Operation
- Internal registers: btn_q, state, col_q[1:0], four 3-bit column heights h0..h3 (0..4), move_cnt[4:0] (0..16).
- Press: btn & ~btn_q. btn_q resets to 1, so a button held through reset does not register a press.
- IDLE: on a press:
  - If sel_col is not one-hot (zero or multiple bits set) or the selected column height is 4: pulse bad_move and stay in IDLE.
  - Otherwise: latch col_q and go to PLACE.
- PLACE (one cycle):
  - Set gameboard[col_q*4+h] = 1 and player_cells at the same bit = player, where h is the height of column col_q.
  - Increment that column's height and move_cnt.
  - Pulse chk_req and go to CHECK.
- CHECK: wait for chk_done.
  - chk_win = 1: status = {player, ~player} (01 for player 0, 10 for player 1); go to OVER.
  - Otherwise, if move_cnt == 16: status = 11; go to OVER.
  - Otherwise: toggle player and go to IDLE.
  - A win takes priority over a draw on the 16th move.
- OVER: the board and status hold; presses are ignored with no bad_move. Only reset exits OVER.
- Presses in PLACE, CHECK or OVER are dropped, not queued, and produce no bad_move.
- chk_done outside CHECK is ignored.
- Heights saturate at 4 by construction, because a full column is rejected in IDLE. move_cnt never exceeds 16.

## Timing
- Reset values:
  - gameboard = 0, player_cells = 0, player = 0, status = 00.
  - chk_req = 0, bad_move = 0, busy = 0.
  - state = IDLE, all heights = 0, move_cnt = 0, btn_q = 1.
- All outputs are registered.
- Valid press sampled at edge k:
  - busy = 1 after k.
  - Board updated and chk_req = 1 after edge k+1, for exactly one cycle.
- Rejected press at edge k: bad_move = 1 for the cycle after k.
- chk_done sampled at edge m in CHECK: player/status updated and busy = 0 after m. Earliest m is k+2.
- The earliest next accepted press is at edge m+1, giving a minimum of 3 cycles per move.
- Reset mid-operation (PLACE or CHECK) clears everything immediately, including a pending chk_req. A late chk_done after reset is ignored.
- chk_done in the same cycle as a press while in CHECK: the press is dropped.

## Test plan
- Reset, then sel_col=0001 with press -> chk_req pulses at k+1, gameboard=0x0001, player_cells=0x0000; chk_done with chk_win=0 -> player=1.
- Second press on column 0 by player 1 -> gameboard=0x0003, player_cells=0x0002. Fill column 0 to 0x000F, then a fifth press -> bad_move pulse, board unchanged, player unchanged.
- Presses with sel_col=0000 and sel_col=0101 -> bad_move pulse each; presses while busy=1 -> ignored with no bad_move.
- Detector returns chk_done with chk_win=1 on player 0's move -> status=01, state OVER; further presses cause no board change and no bad_move.
- Fill all 16 cells alternating, with chk_win=0 throughout -> status=11 after the 16th chk_done. A variant with chk_win=1 on the 16th move -> status=10 (player 1 placed the 16th piece).
- Assert reset while in CHECK with btn held high -> all outputs zero; a subsequent chk_done is ignored; no press is registered until btn falls and rises again.

Source files
------------

// File: rtl/move_sequencer.sv
// Turn controller for the 4x4 Connect-4 board: accepts a column press, drops a piece,
// hands the move to the win detector, alternates players and latches the game result.
module move_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic [3:0]  sel_col,
    input  logic        chk_done,
    input  logic        chk_win,
    output logic [15:0] gameboard,
    output logic [15:0] player_cells,
    output logic        player,
    output logic        chk_req,
    output logic        bad_move,
    output logic [1:0]  status,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PLACE, CHECK, OVER} state_t;

    state_t     state;
    logic       btn_q;
    logic [1:0] col_q;
    logic [2:0] h [4];
    logic [4:0] move_cnt;

    logic       press;
    logic       sel_ok;
    logic [1:0] sel_idx;
    logic [3:0] cell_idx;

    assign press = btn & ~btn_q;

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (sel_col)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    // Only reached in PLACE, where the column height is known to be below 4.
    assign cell_idx = {col_q, h[col_q][1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            btn_q        <= 1'b1;
            col_q        <= 2'd0;
            for (int i = 0; i < 4; i++) h[i] <= 3'd0;
            move_cnt     <= 5'd0;
            gameboard    <= 16'h0;
            player_cells <= 16'h0;
            player       <= 1'b0;
            chk_req      <= 1'b0;
            bad_move     <= 1'b0;
            status       <= 2'b00;
            busy         <= 1'b0;
        end else begin
            btn_q    <= btn;
            chk_req  <= 1'b0;
            bad_move <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (!sel_ok || h[sel_idx] == 3'd4) begin
                            bad_move <= 1'b1;
                        end else begin
                            col_q <= sel_idx;
                            busy  <= 1'b1;
                            state <= PLACE;
                        end
                    end
                end
                PLACE: begin
                    gameboard[cell_idx]    <= 1'b1;
                    player_cells[cell_idx] <= player;
                    h[col_q]               <= h[col_q] + 3'd1;
                    move_cnt               <= move_cnt + 5'd1;
                    chk_req                <= 1'b1;
                    state                  <= CHECK;
                end
                CHECK: begin
                    if (chk_done) begin
                        busy <= 1'b0;
                        // A win on the last cell outranks the draw.
                        if (chk_win) begin
                            status <= {player, ~player};
                            state  <= OVER;
                        end else if (move_cnt == 5'd16) begin
                            status <= 2'b11;
                            state  <= OVER;
                        end else begin
                            player <= ~player;
                            state  <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: single moves, column fill, illegal presses,
// win/draw latching and reset in the middle of a check.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic [3:0]  sel_col;
    logic        chk_done;
    logic        chk_win;
    logic [15:0] gameboard;
    logic [15:0] player_cells;
    logic        player;
    logic        chk_req;
    logic        bad_move;
    logic [1:0]  status;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    move_sequencer dut (
        .clk(clk), .reset(reset), .btn(btn), .sel_col(sel_col),
        .chk_done(chk_done), .chk_win(chk_win),
        .gameboard(gameboard), .player_cells(player_cells), .player(player),
        .chk_req(chk_req), .bad_move(bad_move), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_gb"}, gameboard, 16'h0);
        chk({tag, "_pc"}, player_cells, 16'h0);
        chk({tag, "_pl"}, 16'(player), 16'h0);
        chk({tag, "_st"}, 16'(status), 16'h0);
        chk({tag, "_req"}, 16'(chk_req), 16'h0);
        chk({tag, "_bad"}, 16'(bad_move), 16'h0);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
    endtask

    // One accepted move: press, place, detector answer.
    task automatic do_move(input logic [3:0] col, input logic win,
                           input logic [15:0] gb, input logic [15:0] pc);
        sel_col = col;
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("mv_busy", 16'(busy), 16'h1);
        chk("mv_req_early", 16'(chk_req), 16'h0);
        step();
        chk("mv_req", 16'(chk_req), 16'h1);
        chk("mv_gb", gameboard, gb);
        chk("mv_pc", player_cells, pc);
        chk_done = 1'b1;
        chk_win  = win;
        step();
        chk_done = 1'b0;
        chk_win  = 1'b0;
        chk("mv_req_clr", 16'(chk_req), 16'h0);
        chk("mv_busy_clr", 16'(busy), 16'h0);
    endtask

    task automatic bad_press(input logic [3:0] col, input logic [15:0] gb, input logic pl);
        sel_col = col;
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("bad_pulse", 16'(bad_move), 16'h1);
        chk("bad_busy", 16'(busy), 16'h0);
        chk("bad_gb", gameboard, gb);
        chk("bad_pl", 16'(player), 16'(pl));
        step();
        chk("bad_clr", 16'(bad_move), 16'h0);
    endtask

    // Fill the board column by column; move i lands on bit i, owned by i's parity.
    task automatic fill(input logic last_win);
        logic [15:0] gb = 16'h0;
        logic [15:0] pc = 16'h0;
        logic [3:0]  oh;
        for (int i = 0; i < 16; i++) begin
            gb[i] = 1'b1;
            pc[i] = i[0];
            oh = 4'b0001 << (i / 4);
            do_move(oh, last_win && (i == 15), gb, pc);
            if (i == 14) chk("fill_st15", 16'(status), 16'h0);
        end
    endtask

    initial begin
        reset = 1'b1; btn = 1'b1; sel_col = 4'b0001; chk_done = 1'b0; chk_win = 1'b0;
        step();
        step();
        check_idle_zero("rst");
        reset = 1'b0;
        // Button held through reset must not count as a press.
        step();
        chk("held_busy", 16'(busy), 16'h0);
        chk("held_bad", 16'(bad_move), 16'h0);
        btn = 1'b0;
        step();

        do_move(4'b0001, 1'b0, 16'h0001, 16'h0000);
        chk("p_after1", 16'(player), 16'h1);
        do_move(4'b0001, 1'b0, 16'h0003, 16'h0002);
        chk("p_after2", 16'(player), 16'h0);
        do_move(4'b0001, 1'b0, 16'h0007, 16'h0002);
        do_move(4'b0001, 1'b0, 16'h000F, 16'h000A);
        chk("p_after4", 16'(player), 16'h0);

        bad_press(4'b0001, 16'h000F, 1'b0);
        bad_press(4'b0000, 16'h000F, 1'b0);
        bad_press(4'b0101, 16'h000F, 1'b0);

        // Presses while busy: one in PLACE, one coinciding with chk_done.
        sel_col = 4'b0010;
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("busy_on", 16'(busy), 16'h1);
        btn = 1'b1;
        step();
        chk("place_press_req", 16'(chk_req), 16'h1);
        chk("place_press_bad", 16'(bad_move), 16'h0);
        chk("place_press_gb", gameboard, 16'h001F);
        chk("place_press_pc", player_cells, 16'h000A);
        btn = 1'b0;
        step();
        chk("check_wait_busy", 16'(busy), 16'h1);
        btn = 1'b1;
        chk_done = 1'b1;
        step();
        chk_done = 1'b0;
        chk("coinc_busy", 16'(busy), 16'h0);
        chk("coinc_bad", 16'(bad_move), 16'h0);
        chk("coinc_pl", 16'(player), 16'h1);
        btn = 1'b0;
        step();
        chk("dropped_busy", 16'(busy), 16'h0);
        chk("dropped_gb", gameboard, 16'h001F);

        // Player 1 on column 2, then player 0 wins on column 3.
        do_move(4'b0100, 1'b0, 16'h011F, 16'h010A);
        do_move(4'b1000, 1'b1, 16'h111F, 16'h010A);
        chk("win_st", 16'(status), 16'h1);
        sel_col = 4'b1000;
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("over_bad", 16'(bad_move), 16'h0);
        chk("over_busy", 16'(busy), 16'h0);
        chk("over_gb", gameboard, 16'h111F);
        step();
        chk("over_st", 16'(status), 16'h1);

        do_reset();
        check_idle_zero("rst2");
        fill(1'b0);
        chk("draw_st", 16'(status), 16'h3);

        do_reset();
        fill(1'b1);
        chk("lastwin_st", 16'(status), 16'h2);

        // Reset while waiting in CHECK with the button held.
        do_reset();
        sel_col = 4'b0100;
        btn = 1'b1;
        step();
        btn = 1'b0;
        step();
        chk("mid_req", 16'(chk_req), 16'h1);
        btn = 1'b1;
        reset = 1'b1;
        #1;
        check_idle_zero("async_rst");
        step();
        reset = 1'b0;
        chk_done = 1'b1;
        chk_win = 1'b1;
        step();
        chk_done = 1'b0;
        chk_win = 1'b0;
        chk("late_done_st", 16'(status), 16'h0);
        chk("late_done_pl", 16'(player), 16'h0);
        chk("late_done_busy", 16'(busy), 16'h0);
        step();
        chk("held2_busy", 16'(busy), 16'h0);
        btn = 1'b0;
        step();
        btn = 1'b1;
        step();
        chk("repress_busy", 16'(busy), 16'h1);
        btn = 1'b0;
        step();
        chk("repress_gb", gameboard, 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
